// File: rtl/multi_cycle_cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM states, ALU operations and
// instruction field positions.
package multi_cycle_cpu_pkg;

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b000001;
  localparam logic [5:0] OpSub  = 6'b000010;
  localparam logic [5:0] OpOri  = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOr   = 6'b010010;
  localparam logic [5:0] OpSw   = 6'b100110;
  localparam logic [5:0] OpLw   = 6'b100111;
  localparam logic [5:0] OpBeq  = 6'b110000;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpHalt = 6'b111111;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluOr} alu_op_e;

  localparam int unsigned OpMsb  = 31;
  localparam int unsigned OpLsb  = 26;
  localparam int unsigned RsMsb  = 25;
  localparam int unsigned RsLsb  = 21;
  localparam int unsigned RtMsb  = 20;
  localparam int unsigned RtLsb  = 16;
  localparam int unsigned RdMsb  = 15;
  localparam int unsigned RdLsb  = 11;
  localparam int unsigned ImmMsb = 15;
  localparam int unsigned ImmLsb = 0;
  localparam int unsigned TgtMsb = 25;
  localparam int unsigned TgtLsb = 0;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OpAdd, OpAddi, OpSub, OpOri, OpAnd, OpOr, OpSw, OpLw, OpBeq, OpJ, OpHalt: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// cleared by the asynchronous active-low reset.
module mcc_regfile #(
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && !(ZERO_REG_HARDWIRED && i_waddr == 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (ZERO_REG_HARDWIRED && i_raddr_a == 5'd0) ? 32'h0 : r_regs[i_raddr_a];
  assign o_rdata_b = (ZERO_REG_HARDWIRED && i_raddr_b == 5'd0) ? 32'h0 : r_regs[i_raddr_b];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-style core: FETCH/DECODE/EXEC/MEM/WB state machine sharing one
// req/ack memory port for instruction fetch and data access.
module multi_cycle_cpu #(
  parameter int unsigned ADDR_W             = 32,
  parameter logic [31:0] RESET_PC           = 32'h0,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);
  import multi_cycle_cpu_pkg::*;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir, r_a, r_b, r_imm, r_aluout, r_mdr;
  logic              r_retire, r_illegal;
  logic              w_retire_next, w_illegal_set, w_rf_we, w_is_rtype;
  logic [5:0]        w_op;
  logic [4:0]        w_rs, w_rt, w_rd, w_rf_waddr;
  logic [15:0]       w_imm16;
  logic [25:0]       w_target;
  logic [31:0]       w_imm_ext, w_rs_data, w_rt_data, w_alu_b, w_alu_res, w_rf_wdata;
  logic [ADDR_W-1:0] w_pc_plus4, w_jump_pc, w_branch_pc;
  alu_op_e           w_alu_op;

  assign w_op     = r_ir[OpMsb:OpLsb];
  assign w_rs     = r_ir[RsMsb:RsLsb];
  assign w_rt     = r_ir[RtMsb:RtLsb];
  assign w_rd     = r_ir[RdMsb:RdLsb];
  assign w_imm16  = r_ir[ImmMsb:ImmLsb];
  assign w_target = r_ir[TgtMsb:TgtLsb];

  assign w_is_rtype = (w_op == OpAdd) || (w_op == OpSub) || (w_op == OpAnd) || (w_op == OpOr);
  assign w_imm_ext  = (w_op == OpOri) ? {16'h0, w_imm16} : {{16{w_imm16[15]}}, w_imm16};
  assign w_alu_b    = w_is_rtype ? r_b : r_imm;

  always_comb begin
    w_alu_op = AluAdd;
    case (w_op)
      OpSub:        w_alu_op = AluSub;
      OpAnd:        w_alu_op = AluAnd;
      OpOr, OpOri:  w_alu_op = AluOr;
      default:      w_alu_op = AluAdd;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    unique case (w_alu_op)
      AluAdd:  w_alu_res = r_a + w_alu_b;
      AluSub:  w_alu_res = r_a - w_alu_b;
      AluAnd:  w_alu_res = r_a & w_alu_b;
      AluOr:   w_alu_res = r_a | w_alu_b;
      default: w_alu_res = '0;
    endcase
  end

  // Jump keeps the PC's top region bits above bit 27; works down to ADDR_W = 28.
  assign w_pc_plus4  = r_pc + ADDR_W'(32'd4);
  assign w_jump_pc   = (r_pc & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({w_target, 2'b00});
  assign w_branch_pc = r_pc + ADDR_W'(r_imm << 2);

  assign w_rf_waddr = w_is_rtype ? w_rd : w_rt;
  assign w_rf_wdata = (w_op == OpLw) ? r_mdr : r_aluout;

  mcc_regfile #(
    .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_raddr_a(w_rs),
    .o_rdata_a(w_rs_data),
    .i_raddr_b(w_rt),
    .o_rdata_b(w_rt_data),
    .i_we     (w_rf_we),
    .i_waddr  (w_rf_waddr),
    .i_wdata  (w_rf_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StFetch;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_retire_next = 1'b0;
    w_illegal_set = 1'b0;
    w_rf_we       = 1'b0;
    unique case (r_state)
      StFetch: if (mem_ack) w_state_next = StDecode;
      StDecode: begin
        if (w_op == OpJ) begin
          w_state_next  = StFetch;
          w_retire_next = 1'b1;
        end else if (w_op == OpHalt) begin
          w_state_next  = StHalt;
          w_retire_next = 1'b1;
        end else if (!is_known_op(w_op)) begin
          w_state_next  = StHalt;
          w_illegal_set = 1'b1;
        end else begin
          w_state_next  = StExec;
        end
      end
      StExec: begin
        if (w_op == OpBeq) begin
          w_state_next  = StFetch;
          w_retire_next = 1'b1;
        end else if (w_op == OpLw || w_op == OpSw) begin
          w_state_next  = StMem;
        end else begin
          w_state_next  = StWb;
        end
      end
      StMem: begin
        if (mem_ack) begin
          w_state_next  = (w_op == OpSw) ? StFetch : StWb;
          w_retire_next = (w_op == OpSw);
        end
      end
      StWb: begin
        w_state_next  = StFetch;
        w_retire_next = 1'b1;
        w_rf_we       = 1'b1;
      end
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC[ADDR_W-1:0];
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_aluout  <= '0;
      r_mdr     <= '0;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // Registered so retire never depends combinationally on mem_ack.
      r_retire <= w_retire_next;
      if (w_illegal_set) r_illegal <= 1'b1;
      case (r_state)
        StFetch: begin
          if (mem_ack) begin
            r_ir <= mem_rdata;
            r_pc <= w_pc_plus4;
          end
        end
        StDecode: begin
          r_a   <= w_rs_data;
          r_b   <= w_rt_data;
          r_imm <= w_imm_ext;
          if (w_op == OpJ) r_pc <= w_jump_pc;
        end
        StExec: begin
          r_aluout <= w_alu_res;
          if (w_op == OpBeq && r_a == r_b) r_pc <= w_branch_pc;
        end
        StMem: if (mem_ack && w_op != OpSw) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Reset gates the bus so an abandoned handshake drops at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (r_state == StFetch) begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
      end else if (r_state == StMem) begin
        mem_req   = 1'b1;
        mem_we    = (w_op == OpSw);
        mem_addr  = r_aluout[ADDR_W-1:0];
        mem_wdata = r_b;
      end
    end
  end

  assign pc_out  = r_pc;
  assign retire  = r_retire;
  assign halted  = (r_state == StHalt);
  assign illegal = r_illegal;

endmodule
